// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scanner with frame debounce and a read-to-clear key status word.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [31:0] read_data
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  logic [DW-1:0] div;
  logic [1:0]    r;
  logic [3:0]    col_m, col_s;
  logic [15:0]   snap, prev, stable;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    key_code, idx;
  logic          eval, tick, load, press, valid, overrun;
  always_comb begin
    tick  = div == DW'(SCAN_DIV - 1);
    cnt_n = snap != prev ? '0 : cnt == CW'(DEBOUNCE_FRAMES) ? cnt : cnt + CW'(1);
    load  = eval && cnt_n == CW'(DEBOUNCE_FRAMES) && cnt != CW'(DEBOUNCE_FRAMES) && snap != stable;
    // a press is a release-to-single-key transition; chords and key-to-key moves are ignored
    press = load && stable == '0 && snap != '0 && (snap & (snap - 16'd1)) == '0;
    idx   = '0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) idx = 4'(i);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col_m    <= '0;
      col_s    <= '0;
      div      <= '0;
      r        <= '0;
      eval     <= 1'b0;
      snap     <= '0;
      prev     <= '0;
      cnt      <= '0;
      stable   <= '0;
      key_code <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      col_m <= col;
      col_s <= col_m;
      div   <= tick ? '0 : div + DW'(1);
      eval  <= tick && r == 2'd3;
      if (tick) begin
        snap[{r, 2'b00} +: 4] <= col_s;
        r                     <= r + 2'd1;
      end
      if (eval) begin
        prev <= snap;
        cnt  <= cnt_n;
      end
      if (load) stable <= snap;
      if (press) key_code <= idx;
      valid   <= press | (valid & ~MemRead);
      overrun <= ~MemRead & (overrun | (press & valid));
    end
  assign row       = 4'b0001 << r;
  assign read_data = {valid, overrun, 10'b0, stable, key_code};
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan order, debounce, press events and read-to-clear status.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic [3:0]  col, row;
  logic [31:0] read_data;
  logic [15:0] keys = '0;
  int          n = 0;
  int          checks = 0;
  int          passes = 0;
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .col(col), .row(row), .read_data(read_data)
  );
  always #5 clk = ~clk;
  // emulate the key matrix: a pressed key shorts its row drive onto its column
  always_comb begin
    col = '0;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++)
        if (row[i] && keys[4*i+c]) col[c] = 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
  endtask
  task automatic step_to(input int t);
    while (n < t) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic do_reset();
    keys = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
  endtask
  task automatic row_seq(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("row_seq", 32'(row), 32'(1) << ((i / 4) % 4));
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_rd", read_data, 32'h0);
    check("reset_row", 32'(row), 32'h1);
    reset = 1'b0;
    n = 0;
    row_seq(16);
    step_to(80);
    check("idle_rd", read_data, 32'h0);
    // hold key 9: stable and the event land on the third identical frame's evaluation edge
    do_reset();
    keys = 16'h0200;
    step_to(48);
    check("k9_pre", read_data, 32'h0);
    step_to(49);
    check("k9_event", read_data, 32'h8000_2009);
    step_to(64);
    MemRead = 1'b1;
    check("k9_preclear", read_data, 32'h8000_2009);
    step_to(65);
    MemRead = 1'b0;
    check("k9_read", read_data, 32'h0000_2009);
    step_to(72);
    check("row2_before_rst", 32'(row), 32'h4);
    reset = 1'b1;
    #1;
    check("midrst_rd", read_data, 32'h0);
    check("midrst_row", 32'(row), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    row_seq(8);
    // key 9 bouncing every frame never settles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      keys = (k % 2 == 0) ? 16'h0200 : 16'h0000;
      step_to(16 * k + 16);
      check("toggle", read_data, 32'h0);
    end
    // chord of keys 0 and 5 becomes stable but raises no event
    do_reset();
    keys = 16'h0021;
    step_to(80);
    check("chord", read_data, 32'h0000_0210);
    // key 3 then key 7 without reading: overrun, then read-to-clear, then coincident read
    do_reset();
    keys = 16'h0008;
    step_to(64);
    check("k3_press", read_data, 32'h8000_0083);
    keys = 16'h0000;
    step_to(128);
    check("k3_release", read_data, 32'h8000_0003);
    keys = 16'h0080;
    step_to(192);
    check("k7_overrun", read_data, 32'hC000_0807);
    MemRead = 1'b1;
    step_to(193);
    MemRead = 1'b0;
    check("k7_read", read_data, 32'h0000_0807);
    step_to(208);
    keys = 16'h0008;
    step_to(272);
    check("k7_to_k3_noevent", read_data, 32'h0000_0087);
    keys = 16'h0000;
    step_to(336);
    check("k3_release2", read_data, 32'h0000_0007);
    keys = 16'h0008;
    step_to(400);
    check("k3_press2", read_data, 32'h8000_0083);
    keys = 16'h0000;
    step_to(464);
    check("k3_release3", read_data, 32'h8000_0003);
    keys = 16'h0080;
    step_to(512);
    MemRead = 1'b1;
    check("coinc_pre", read_data, 32'h8000_0003);
    step_to(513);
    MemRead = 1'b0;
    check("coinc_event", read_data, 32'h8000_0807);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
